// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bus-attached 8N1 UART transmitter with a byte FIFO,
// programmable baud divisor and a level TX-empty interrupt.
module uart_tx_dev #(
  parameter int unsigned FifoDepth    = 8,
  parameter int unsigned DefaultDiv   = 16,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                    ck_i,
  input  logic                    rs_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wd_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rd_o,
  output logic                    err_o,
  output logic                    tx_o,
  output logic                    irq_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(FifoDepth);
  localparam logic [15:0]     DivRst = 16'(DefaultDiv);

  localparam logic [11:0] OffTxData = 12'h000;
  localparam logic [11:0] OffStatus = 12'h004;
  localparam logic [11:0] OffDiv    = 12'h008;
  localparam logic [11:0] OffIrqEn  = 12'h00C;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [7:0]           fifo_q [FifoDepth];
  logic [7:0]           fifo_d [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [15:0]          div_q, div_d;
  logic [15:0]          frame_div_q, frame_div_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q, ovf_d;
  logic                 irqen_q, irqen_d;
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rd_q, rd_d;
  logic                 err_q, err_d;
  logic                 irq_q, irq_d;

  logic                 fifo_empty, fifo_full, busy, pop, push;
  logic [11:0]          off;
  logic [15:0]          div_new;
  logic                 unused_bits;

  // Bus bits outside the decoded register window are ignored.
  always_comb unused_bits = ^{be_i[3:2], addr_i[AddressWidth-1:12], wd_i[DataWidth-1:16]};

  // Next-state logic: serialiser, FIFO, register file and bus response.
  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    div_d       = div_q;
    frame_div_d = frame_div_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ovf_d       = ovf_q;
    irqen_d     = irqen_q;
    rvalid_d    = req_i;
    rd_d        = '0;
    err_d       = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    div_new     = div_q;
    off         = addr_i[11:0];
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == DepthC);
    busy        = (state_q != IDLE);
    irq_d       = irqen_q & fifo_empty & (state_q == IDLE);

    // Serialiser: cnt_q counts down the cycles left in the current bit.
    case (state_q)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      START: begin
        if (cnt_q == '0) begin
          state_d   = DATA;
          cnt_d     = frame_div_q - 16'd1;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = frame_div_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop starts a new frame; the divisor is frozen for the whole frame.
    if (pop) begin
      state_d     = START;
      shift_d     = fifo_q[rd_ptr_q];
      frame_div_d = div_q;
      cnt_d       = div_q - 16'd1;
      tx_d        = 1'b0;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end

    // Register access; read data reflects state in the request cycle.
    if (req_i) begin
      case (off)
        OffTxData: begin
          if (we_i && be_i[0]) begin
            if (!fifo_full || pop) begin
              push = 1'b1;
            end else begin
              ovf_d = 1'b1;
              err_d = 1'b1;
            end
          end
        end
        OffStatus: begin
          if (we_i) begin
            if (be_i[0] && wd_i[3]) ovf_d = 1'b0;
          end else begin
            rd_d[11:0] = {4'(count_q), 4'b0000, ovf_q, busy, fifo_empty, fifo_full};
          end
        end
        OffDiv: begin
          if (we_i) begin
            if (be_i[0]) div_new[7:0]  = wd_i[7:0];
            if (be_i[1]) div_new[15:8] = wd_i[15:8];
            if (be_i[1:0] != 2'b00) div_d = (div_new == '0) ? 16'd1 : div_new;
          end else begin
            rd_d[15:0] = div_q;
          end
        end
        OffIrqEn: begin
          if (we_i) begin
            if (be_i[0]) irqen_d = wd_i[0];
          end else begin
            rd_d[0] = irqen_q;
          end
        end
        default: err_d = 1'b1;
      endcase
    end

    // A push into a full FIFO is legal only alongside a pop, keeping count.
    if (push) begin
      fifo_d[wr_ptr_q] = wd_i[7:0];
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset; reset abandons any frame at once.
  always_ff @(posedge ck_i) begin
    if (rs_i) begin
      state_q     <= IDLE;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      div_q       <= DivRst;
      frame_div_q <= DivRst;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      ovf_q       <= 1'b0;
      irqen_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      div_q       <= div_d;
      frame_div_q <= frame_div_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ovf_q       <= ovf_d;
      irqen_q     <= irqen_d;
      rvalid_q    <= rvalid_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rd_o     = rd_q;
  assign err_o    = err_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: bus responses and received serial bytes
// are checked against expectation queues filled as stimulus is driven.
module tb_uart_tx_dev;

  localparam logic [11:0] A_TXDATA = 12'h000;
  localparam logic [11:0] A_STATUS = 12'h004;
  localparam logic [11:0] A_DIV    = 12'h008;
  localparam logic [11:0] A_IRQEN  = 12'h00C;

  logic        clk;
  logic        rs_i, req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wd_i;
  logic        rvalid_o, err_o, tx_o, irq_o;
  logic [31:0] rd_o;

  uart_tx_dev #(.FifoDepth(8), .DefaultDiv(16), .DataWidth(32), .AddressWidth(32)) dut (
    .ck_i    (clk),
    .rs_i    (rs_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .be_i    (be_i),
    .addr_i  (addr_i),
    .wd_i    (wd_i),
    .rvalid_o(rvalid_o),
    .rd_o    (rd_o),
    .err_o   (err_o),
    .tx_o    (tx_o),
    .irq_o   (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       tag;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [7:0] rx_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       req_seen;
  rsp_t       mon_e;
  logic       rx_en;
  int         rx_div;
  int         rx_d;
  logic [7:0] rx_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge; its expected response is queued.
  task automatic bus(input logic we, input logic [3:0] be, input logic [11:0] a,
                     input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                     input string tag);
    rsp_t r;
    req_i  = 1'b1;
    we_i   = we;
    be_i   = be;
    addr_i = {20'h0, a};
    wd_i   = wd;
    r.rd   = erd;
    r.err  = eerr;
    r.tag  = tag;
    rsp_q.push_back(r);
    @(negedge clk);
    req_i  = 1'b0;
    we_i   = 1'b0;
    be_i   = 4'h0;
    addr_i = '0;
    wd_i   = '0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d,
                    input logic eerr, input string tag);
    bus(1'b1, be, a, d, 32'h0, eerr, tag);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic eerr,
                    input string tag);
    bus(1'b0, 4'hF, a, 32'h0, exp, eerr, tag);
  endtask

  // Caller is at the negedge of the first start-bit cycle.
  task automatic expect_frame(input logic [7:0] b, input int d, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < d; k++) begin
        check({tag, " line"}, 32'(tx_o), 32'(bits[i]));
        @(negedge clk);
      end
    end
  endtask

  always @(posedge clk) req_seen <= req_i;

  // Response monitor: one response per request, exactly one cycle later.
  always @(negedge clk) begin
    check("rvalid timing", 32'(rvalid_o), 32'(req_seen));
    if (rvalid_o === 1'b1 && rsp_q.size() != 0) begin
      mon_e = rsp_q.pop_front();
      check({mon_e.tag, " rd"}, rd_o, mon_e.rd);
      check({mon_e.tag, " err"}, 32'(err_o), 32'(mon_e.err));
    end else if (rvalid_o === 1'b0) begin
      check("rd idle zero", rd_o, 32'h0);
    end
  end

  // Line receiver: samples mid-bit at the divisor the bench programmed.
  always begin
    @(negedge clk);
    if (rx_en && tx_o === 1'b0) begin
      rx_d = rx_div;
      repeat (rx_d / 2) @(negedge clk);
      check("rx start bit", 32'(tx_o), 32'h0);
      for (int i = 0; i < 8; i++) begin
        repeat (rx_d) @(negedge clk);
        rx_b[i] = tx_o;
      end
      repeat (rx_d) @(negedge clk);
      check("rx stop bit", 32'(tx_o), 32'h1);
      check("rx frame expected", 32'(rx_q.size() != 0), 32'h1);
      if (rx_q.size() != 0) check("rx byte", 32'(rx_b), 32'(rx_q.pop_front()));
    end
  end

  initial begin
    int lows;
    rs_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wd_i = '0;
    rx_en = 1'b0; rx_div = 16;
    repeat (2) @(negedge clk);
    rs_i = 1'b0;

    // Reset defaults
    check("reset tx", 32'(tx_o), 32'h1);
    check("reset irq", 32'(irq_o), 32'h0);
    rd(A_STATUS, 32'h002, 1'b0, "reset STATUS");
    rd(A_DIV,    32'h010, 1'b0, "reset DIV");
    rd(A_IRQEN,  32'h000, 1'b0, "reset IRQEN");
    rx_en = 1'b1;

    // Errors and edge writes
    rd(12'h010, 32'h0, 1'b1, "bad offset read");
    wr(12'h014, 4'hF, 32'hFFFF, 1'b1, "bad offset write");
    rd(A_DIV, 32'h010, 1'b0, "DIV after bad write");
    wr(A_DIV, 4'h3, 32'h0, 1'b0, "DIV write 0");
    rd(A_DIV, 32'h001, 1'b0, "DIV zero stored as 1");
    wr(A_DIV, 4'h2, 32'h1234, 1'b0, "DIV upper byte");
    rd(A_DIV, 32'h1201, 1'b0, "DIV byte enables");
    wr(A_TXDATA, 4'h0, 32'h55, 1'b0, "TXDATA be0");
    rd(A_STATUS, 32'h002, 1'b0, "STATUS after be0 push");
    rd(A_TXDATA, 32'h0, 1'b0, "TXDATA read");

    // Single byte, write-to-line latency and frame shape
    wr(A_DIV, 4'h3, 32'h4, 1'b0, "DIV=4");
    rx_div = 4;
    rx_q.push_back(8'hA5);
    wr(A_TXDATA, 4'h1, 32'hA5, 1'b0, "TXDATA A5");
    check("line high before start", 32'(tx_o), 32'h1);
    @(negedge clk);
    expect_frame(8'hA5, 4, "frame A5");
    check("line idle after frame", 32'(tx_o), 32'h1);
    rd(A_STATUS, 32'h002, 1'b0, "STATUS after frame");

    // Back-to-back frames and interrupt
    wr(A_DIV, 4'h3, 32'h2, 1'b0, "DIV=2");
    wr(A_IRQEN, 4'h1, 32'h1, 1'b0, "IRQEN=1");
    rd(A_IRQEN, 32'h1, 1'b0, "IRQEN readback");
    check("irq idle enabled", 32'(irq_o), 32'h1);
    rx_div = 2;
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    wr(A_TXDATA, 4'h1, 32'h01, 1'b0, "TXDATA 01");
    wr(A_TXDATA, 4'h1, 32'h02, 1'b0, "TXDATA 02");
    check("irq low while sending", 32'(irq_o), 32'h0);
    expect_frame(8'h01, 2, "frame 01");
    expect_frame(8'h02, 2, "frame 02");
    check("irq lag at idle", 32'(irq_o), 32'h0);
    @(negedge clk);
    check("irq after idle", 32'(irq_o), 32'h1);

    // Push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 9; i++) begin
      rx_q.push_back(8'(8'h30 + i));
      wr(A_TXDATA, 4'h1, 32'(8'h30 + i), 1'b0, "fill push");
    end
    repeat (12) @(negedge clk);
    rx_q.push_back(8'h39);
    wr(A_TXDATA, 4'h1, 32'h39, 1'b0, "push with pop at full");
    repeat (220) @(negedge clk);
    rd(A_STATUS, 32'h002, 1'b0, "STATUS after drain");
    check("rx queue drained", 32'(rx_q.size()), 32'h0);

    // Overflow
    rx_en = 1'b0;
    wr(A_DIV, 4'h3, 32'd100, 1'b0, "DIV=100");
    for (int i = 0; i < 10; i++) begin
      wr(A_TXDATA, 4'h1, 32'(i), (i == 9), "overflow push");
    end
    rd(A_STATUS, 32'h80D, 1'b0, "STATUS overflow");
    wr(A_STATUS, 4'h1, 32'h8, 1'b0, "clear overflow");
    rd(A_STATUS, 32'h805, 1'b0, "STATUS overflow cleared");
    rs_i = 1'b1;
    repeat (2) @(negedge clk);
    rs_i = 1'b0;

    // Reset in the middle of a data bit
    wr(A_DIV, 4'h3, 32'h4, 1'b0, "DIV=4 again");
    wr(A_IRQEN, 4'h1, 32'h1, 1'b0, "IRQEN=1 again");
    wr(A_TXDATA, 4'h1, 32'h00, 1'b0, "TXDATA 00");
    repeat (7) @(negedge clk);
    check("data bit low before reset", 32'(tx_o), 32'h0);
    rs_i = 1'b1;
    @(negedge clk);
    rs_i = 1'b0;
    check("tx high after reset", 32'(tx_o), 32'h1);
    check("irq low after reset", 32'(irq_o), 32'h0);
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    check("no bits after reset", 32'(lows), 32'h0);
    rd(A_STATUS, 32'h002, 1'b0, "STATUS after mid reset");
    rd(A_DIV,    32'h010, 1'b0, "DIV after mid reset");
    rd(A_IRQEN,  32'h000, 1'b0, "IRQEN after mid reset");
    @(negedge clk);
    check("responses drained", 32'(rsp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
